// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and op classification for seq_alu.
package alu_pkg;

  localparam logic [4:0] OP_OR   = 5'd0;
  localparam logic [4:0] OP_AND  = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_MUL  = 5'd4;
  localparam logic [4:0] OP_DIV  = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_SHL  = 5'd7;
  localparam logic [4:0] OP_SHR  = 5'd8;
  localparam logic [4:0] OP_SHRA = 5'd9;
  localparam logic [4:0] OP_ROR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_NEG  = 5'd12;
  localparam logic [4:0] OP_NOT  = 5'd13;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Everything except MUL and a real DIV finishes in one cycle; DIV by zero
  // short-circuits to the single-cycle path.
  function automatic logic is_single_cycle(logic [4:0] op, logic b_zero);
    return !((op == OP_MUL) || ((op == OP_DIV) && !b_zero));
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Shared iterative engine: radix-2 Booth multiply and restoring divide,
// one bit per step, with sign correction applied on the result outputs.
module iter_muldiv #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  fix_i,
  input  logic                  div_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  last_o,
  output logic [DATA_WIDTH-1:0] lo_o,
  output logic [DATA_WIDTH-1:0] hi_o
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

  // acc is one bit wider so Booth partial sums and restoring trial
  // subtractions never overflow.
  logic [W:0]       acc_q, acc_d;
  logic [W-1:0]     q_q, q_d;
  logic [W-1:0]     m_q, m_d;
  logic             qm1_q, qm1_d;
  logic             div_q, div_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W:0]   m_ext, booth_sum, r_sh, r_sub;
  logic [W-1:0] a_abs, b_abs;

  // Next-state for load, one iteration step, or clearing after FIX.
  always_comb begin
    acc_d  = acc_q;
    q_d    = q_q;
    m_d    = m_q;
    qm1_d  = qm1_q;
    div_d  = div_q;
    negq_d = negq_q;
    negr_d = negr_q;
    cnt_d  = cnt_q;

    a_abs = a_i[W-1] ? ('0 - a_i) : a_i;
    b_abs = b_i[W-1] ? ('0 - b_i) : b_i;
    m_ext = {m_q[W-1], m_q};
    unique case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    r_sh  = {acc_q[W-1:0], q_q[W-1]};
    r_sub = r_sh - {1'b0, m_q};

    if (load_i) begin
      cnt_d = CNT_W'(DATA_WIDTH);
      div_d = div_i;
      acc_d = '0;
      qm1_d = 1'b0;
      if (div_i) begin
        q_d    = a_abs;
        m_d    = b_abs;
        negq_d = a_i[W-1] ^ b_i[W-1];
        negr_d = a_i[W-1];
      end else begin
        q_d    = b_i;
        m_d    = a_i;
        negq_d = 1'b0;
        negr_d = 1'b0;
      end
    end else if (step_i) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (div_q) begin
        if (!r_sub[W]) begin
          acc_d = r_sub;
          q_d   = {q_q[W-2:0], 1'b1};
        end else begin
          acc_d = r_sh;
          q_d   = {q_q[W-2:0], 1'b0};
        end
      end else begin
        // Arithmetic right shift of {acc, q, q-1}.
        acc_d = {booth_sum[W], booth_sum[W:1]};
        q_d   = {booth_sum[0], q_q[W-1:1]};
        qm1_d = q_q[0];
      end
    end else if (fix_i) begin
      // The top latches lo_o/hi_o on this edge; the engine then goes quiet.
      acc_d  = '0;
      q_d    = '0;
      m_d    = '0;
      qm1_d  = 1'b0;
      div_d  = 1'b0;
      negq_d = 1'b0;
      negr_d = 1'b0;
      cnt_d  = '0;
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      q_q    <= '0;
      m_q    <= '0;
      qm1_q  <= 1'b0;
      div_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      q_q    <= q_d;
      m_q    <= m_d;
      qm1_q  <= qm1_d;
      div_q  <= div_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));
  // Quotient negates on differing signs; remainder follows the dividend.
  assign lo_o   = negq_q ? ('0 - q_q) : q_q;
  assign hi_o   = negr_q ? ('0 - acc_q[W-1:0]) : acc_q[W-1:0];

endmodule

// File: rtl/seq_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops plus iterative signed
// multiply and divide behind a start/busy/done handshake.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  start,
  input  logic [4:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result_low,
  output logic [DATA_WIDTH-1:0] result_high,
  output logic                  carry,
  output logic                  div_by_zero,
  output logic                  illegal_op
);

  localparam int unsigned W = DATA_WIDTH;

  logic [1:0]   state_q, state_d;
  logic         sc_load, md_load, md_step, md_fix, md_last;
  logic [W-1:0] md_lo, md_hi;
  logic [W-1:0] lo_q, hi_q;
  logic         carry_q, dbz_q, ill_q;

  logic [W:0]         add_w, sub_w;
  logic [SHAMT_W-1:0] shamt;
  logic [W-1:0]       sc_lo, sc_hi;
  logic               sc_carry, sc_dbz, sc_ill;

  assign shamt = B[SHAMT_W-1:0];

  // Single-cycle op results; MUL never lands here and DIV only with B == 0.
  always_comb begin
    add_w    = {1'b0, A} + {1'b0, B};
    sub_w    = {1'b0, A} + {1'b0, ~B} + (W + 1)'(1);
    sc_lo    = '0;
    sc_hi    = '0;
    sc_carry = 1'b0;
    sc_dbz   = 1'b0;
    sc_ill   = 1'b0;
    case (op)
      OP_OR:   sc_lo = A | B;
      OP_AND:  sc_lo = A & B;
      OP_XOR:  sc_lo = A ^ B;
      OP_ADD:  begin sc_lo = add_w[W-1:0]; sc_carry = add_w[W]; end
      OP_SUB:  begin sc_lo = sub_w[W-1:0]; sc_carry = sub_w[W]; end
      OP_MUL:  sc_lo = '0;
      OP_DIV:  begin sc_lo = '1; sc_hi = A; sc_dbz = 1'b1; end
      OP_SHL:  sc_lo = A << shamt;
      OP_SHR:  sc_lo = A >> shamt;
      OP_SHRA: sc_lo = W'($signed(A) >>> shamt);
      OP_ROR:  sc_lo = W'({A, A} >> shamt);
      OP_ROL:  sc_lo = W'(({A, A} << shamt) >> W);
      OP_NEG:  sc_lo = '0 - A;
      OP_NOT:  sc_lo = ~A;
      default: sc_ill = 1'b1;
    endcase
  end

  // Control FSM: starts are only sampled in IDLE.
  always_comb begin
    state_d = state_q;
    sc_load = 1'b0;
    md_load = 1'b0;
    md_step = 1'b0;
    md_fix  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_single_cycle(op, B == '0)) begin
            sc_load = 1'b1;
            state_d = ST_DONE;
          end else begin
            md_load = 1'b1;
            state_d = ST_ITER;
          end
        end
      end
      ST_ITER: begin
        md_step = 1'b1;
        if (md_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        md_fix  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Result registers, held until the next completed operation.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      lo_q    <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      dbz_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else if (sc_load) begin
      lo_q    <= sc_lo;
      hi_q    <= sc_hi;
      carry_q <= sc_carry;
      dbz_q   <= sc_dbz;
      ill_q   <= sc_ill;
    end else if (md_fix) begin
      lo_q    <= md_lo;
      hi_q    <= md_hi;
      carry_q <= 1'b0;
      dbz_q   <= 1'b0;
      ill_q   <= 1'b0;
    end
  end

  iter_muldiv #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_iter_muldiv (
    .clk_i (clock),
    .rst_ni(clear_n),
    .load_i(md_load),
    .step_i(md_step),
    .fix_i (md_fix),
    .div_i (op == OP_DIV),
    .a_i   (A),
    .b_i   (B),
    .last_o(md_last),
    .lo_o  (md_lo),
    .hi_o  (md_hi)
  );

  assign busy        = (state_q == ST_ITER) || (state_q == ST_FIX);
  assign done        = (state_q == ST_DONE);
  assign result_low  = lo_q;
  assign result_high = hi_q;
  assign carry       = carry_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (DATA_WIDTH = 32).
module tb_seq_alu;

  logic        clock;
  logic        clear_n;
  logic        start;
  logic [4:0]  op;
  logic [31:0] A, B;
  logic        busy, done, carry, div_by_zero, illegal_op;
  logic [31:0] result_low, result_high;

  int tests = 0;
  int fails = 0;

  seq_alu #(.DATA_WIDTH(32)) dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .start      (start),
    .op         (op),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .result_low (result_low),
    .result_high(result_high),
    .carry      (carry),
    .div_by_zero(div_by_zero),
    .illegal_op (illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure edges from the accepting edge to done, check results.
  task automatic do_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int lat_exp, input logic [31:0] lo_exp,
                       input logic [31:0] hi_exp, input logic c_exp, input logic z_exp,
                       input logic i_exp);
    int lat;
    @(negedge clock);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clock); #1;
    start = 1'b0; A = $urandom; B = $urandom;
    if (lat_exp > 0) check({tag, ".busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, ".lat"},   lat, lat_exp);
    check({tag, ".lo"},    result_low, lo_exp);
    check({tag, ".hi"},    result_high, hi_exp);
    check({tag, ".flags"}, {29'd0, carry, div_by_zero, illegal_op}, {29'd0, c_exp, z_exp, i_exp});
    @(posedge clock); #1;
    check({tag, ".pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    logic seen_done;
    clear_n = 1'b0; start = 1'b0; op = 5'd0; A = '0; B = '0;
    #12;
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.res",  result_low | result_high, 32'd0);
    check("rst.flags", {29'd0, carry, div_by_zero, illegal_op}, 32'd0);
    @(negedge clock); clear_n = 1'b1;

    do_op("mul_m7x6",  5'd4,  32'hFFFF_FFF9, 32'd6,        33, 32'hFFFF_FFD6, 32'hFFFF_FFFF, 0, 0, 0);
    do_op("mul_min2",  5'd4,  32'h8000_0000, 32'h8000_0000, 33, 32'h0,        32'h4000_0000, 0, 0, 0);
    do_op("mul_m1m1",  5'd4,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h1,        32'h0,         0, 0, 0);
    do_op("div_m17d5", 5'd5,  32'hFFFF_FFEF, 32'd5,        33, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 0, 0, 0);
    do_op("div_min",   5'd5,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'h0,        0, 0, 0);
    do_op("div_100d7", 5'd5,  32'd100,       32'd7,        33, 32'd14,       32'd2,         0, 0, 0);
    do_op("div_zero",  5'd5,  32'd100,       32'd0,        0,  32'hFFFF_FFFF, 32'd100,      0, 1, 0);
    do_op("ror4",      5'd10, 32'h8000_0001, 32'd4,        0,  32'h1800_0000, 32'h0,        0, 0, 0);
    do_op("ror0",      5'd10, 32'h1234_5678, 32'h20,       0,  32'h1234_5678, 32'h0,        0, 0, 0);
    do_op("rol4",      5'd11, 32'h8000_0001, 32'd4,        0,  32'h0000_0018, 32'h0,        0, 0, 0);
    do_op("shra31",    5'd9,  32'h8000_0000, 32'd31,       0,  32'hFFFF_FFFF, 32'h0,        0, 0, 0);
    do_op("shr4",      5'd8,  32'h8000_0000, 32'd4,        0,  32'h0800_0000, 32'h0,        0, 0, 0);
    do_op("shl3",      5'd7,  32'h8000_0001, 32'd3,        0,  32'h0000_0008, 32'h0,        0, 0, 0);
    do_op("add_wrap",  5'd2,  32'hFFFF_FFFF, 32'd1,        0,  32'h0,        32'h0,         1, 0, 0);
    do_op("sub_brw",   5'd3,  32'd5,         32'd7,        0,  32'hFFFF_FFFE, 32'h0,        0, 0, 0);
    do_op("sub_ok",    5'd3,  32'd7,         32'd5,        0,  32'd2,        32'h0,         1, 0, 0);
    do_op("logic_or",  5'd0,  32'hF0F0_0000, 32'h0000_0F0F, 0, 32'hF0F0_0F0F, 32'h0,        0, 0, 0);
    do_op("logic_and", 5'd1,  32'hFF00_FF00, 32'h0FF0_0FF0, 0, 32'h0F00_0F00, 32'h0,        0, 0, 0);
    do_op("logic_xor", 5'd6,  32'hFFFF_0000, 32'h0F0F_0F0F, 0, 32'hF0F0_0F0F, 32'h0,        0, 0, 0);
    do_op("neg",       5'd12, 32'd1,         32'd0,        0,  32'hFFFF_FFFF, 32'h0,        0, 0, 0);
    do_op("not",       5'd13, 32'h0000_FFFF, 32'd0,        0,  32'hFFFF_0000, 32'h0,        0, 0, 0);
    do_op("illegal",   5'd20, 32'd1,         32'd2,        0,  32'h0,        32'h0,         0, 0, 1);

    // Start while busy is ignored; start during DONE is ignored too.
    @(negedge clock);
    start = 1'b1; op = 5'd4; A = 32'd3; B = 32'd5;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    start = 1'b1; op = 5'd2; A = 32'd1; B = 32'd2;
    @(negedge clock);
    start = 1'b0;
    lat = 5;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clock); #1;
      lat++;
    end
    check("ign.lat", lat, 33);
    check("ign.lo",  result_low, 32'd15);
    check("ign.hi",  result_high, 32'd0);
    @(negedge clock);
    start = 1'b1; op = 5'd2; A = 32'd1; B = 32'd2;
    @(posedge clock); #1;
    check("ign.done_gap", {31'd0, done}, 32'd0);
    check("ign.hold",     result_low, 32'd15);
    @(posedge clock); #1;
    start = 1'b0;
    check("ign.next_done", {31'd0, done}, 32'd1);
    check("ign.next_lo",   result_low, 32'd3);

    // Asynchronous reset in the middle of a divide.
    @(negedge clock);
    start = 1'b1; op = 5'd5; A = 32'd100; B = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    clear_n = 1'b0;
    #1;
    check("arst.busy", {31'd0, busy}, 32'd0);
    check("arst.done", {31'd0, done}, 32'd0);
    check("arst.lo",   result_low, 32'd0);
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    @(negedge clock); clear_n = 1'b1;
    repeat (40) begin
      @(posedge clock); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("arst.no_done", {31'd0, seen_done}, 32'd0);
    do_op("mul_3x4", 5'd4, 32'd3, 32'd4, 33, 32'd12, 32'd0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
